// File: rtl/scandoubler.sv
// Scan doubler: buffers one 15 kHz input line and replays it twice at
// the doubled pixel rate, with optional darkening of the repeated line.
module scandoubler #(
    parameter int HCNT_WIDTH = 10
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce_x1,
    input  logic       ce_x2,
    input  logic [1:0] scanlines,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    output logic       hs_out,
    output logic       vs_out,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out
);

    localparam int DEPTH = 2 ** (HCNT_WIDTH + 1);

    logic [HCNT_WIDTH-1:0] hcnt_in;
    logic [HCNT_WIDTH-1:0] hmax;
    logic [HCNT_WIDTH-1:0] hs_len;
    logic [HCNT_WIDTH-1:0] hs_width;
    logic [HCNT_WIDTH-1:0] hcnt_out;
    logic                  bank;
    logic                  hs_prev;
    logic                  vs_hold;
    logic                  vs_line;
    logic                  line_odd;

    logic [17:0] line_buf [DEPTH];

    logic [17:0] rd_pix;
    logic        rd_odd;
    logic        rd_hs;
    logic        rd_vs;

    logic line_start;
    logic hs_rise;
    logic in_sat;
    logic out_wrap;

    assign line_start = ce_x1 & hs_prev & ~hs_in;
    assign hs_rise    = ce_x1 & ~hs_prev & hs_in;
    assign in_sat     = (hcnt_in == '1);
    assign out_wrap   = (hcnt_out == hmax);

    // Scanline darkening of one channel; only the repeated line is dimmed.
    function automatic logic [5:0] dim(
        input logic [5:0] c,
        input logic       odd,
        input logic [1:0] sl
    );
        logic [5:0] res;
        res = c;
        if (odd) begin
            case (sl)
                2'd1:    res = c - {2'b00, c[5:2]};
                2'd2:    res = {1'b0, c[5:1]};
                2'd3:    res = {2'b00, c[5:2]};
                default: res = c;
            endcase
        end
        return res;
    endfunction

    // Input side: line start detection, pixel counter, sync width capture.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcnt_in  <= '0;
            hmax     <= '1;
            bank     <= 1'b0;
            vs_hold  <= 1'b1;
            hs_prev  <= 1'b0;
            hs_len   <= '0;
            hs_width <= '0;
        end else if (ce_x1) begin
            hs_prev <= hs_in;
            if (line_start) begin
                hmax    <= hcnt_in;
                hcnt_in <= '0;
                bank    <= ~bank;
                vs_hold <= vs_in;
                hs_len  <= {{(HCNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                if (!in_sat)
                    hcnt_in <= hcnt_in + 1'b1;
                if (!hs_in && hs_len != '1)
                    hs_len <= hs_len + 1'b1;
                if (hs_rise)
                    hs_width <= hs_len;
            end
        end
    end

    // Line buffer write; contents survive reset on purpose.
    always_ff @(posedge clk_sys) begin
        if (!reset && ce_x1 && !in_sat)
            line_buf[{bank, hcnt_in}] <= {r_in, g_in, b_in};
    end

    // Output side: doubled-rate counter, even/odd line and frame sync.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcnt_out <= '0;
            line_odd <= 1'b0;
            vs_line  <= 1'b1;
        end else if (ce_x2) begin
            if (line_start) begin
                hcnt_out <= '0;
                line_odd <= 1'b0;
                vs_line  <= vs_hold;
            end else if (out_wrap) begin
                hcnt_out <= '0;
                line_odd <= 1'b1;
            end else begin
                hcnt_out <= hcnt_out + 1'b1;
            end
        end
    end

    // First delay stage: registered buffer read plus matching side signals.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_pix <= '0;
            rd_odd <= 1'b0;
            rd_hs  <= 1'b1;
            rd_vs  <= 1'b1;
        end else if (ce_x2) begin
            rd_pix <= line_buf[{~bank, hcnt_out}];
            rd_odd <= line_odd;
            rd_hs  <= (hcnt_out >= hs_width);
            rd_vs  <= vs_line;
        end
    end

    // Second delay stage: darken and register the outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
            hs_out <= 1'b1;
            vs_out <= 1'b1;
        end else if (ce_x2) begin
            r_out  <= dim(rd_pix[17:12], rd_odd, scanlines);
            g_out  <= dim(rd_pix[11:6], rd_odd, scanlines);
            b_out  <= dim(rd_pix[5:0], rd_odd, scanlines);
            hs_out <= rd_hs;
            vs_out <= rd_vs;
        end
    end

endmodule
